// File: rtl/ysyx_24100006_pkg.sv
// rtl/ysyx_24100006_pkg.sv - shared constants and IFU state encoding
package ysyx_24100006_pkg;

    localparam logic [31:0] RESET_PC  = 32'h8000_0000;
    localparam logic [1:0]  RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        S_AR  = 2'd0,
        S_R   = 2'd1,
        S_OUT = 2'd2
    } ifu_state_t;

endpackage

// File: rtl/ysyx_24100006_ifu_if.sv
// rtl/ysyx_24100006_ifu_if.sv - IFU redirect, AXI4-Lite read and IF/ID handshake bundle
interface ysyx_24100006_ifu_if;

    logic        flush_i;
    logic [31:0] redirect_pc_i;

    logic        arvalid_o;
    logic        arready_i;
    logic [31:0] araddr_o;
    logic        rvalid_i;
    logic        rready_o;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_o;
    logic [31:0] instruction_o;
    logic        fetch_err_o;

    // IFU side
    modport master (
        input  flush_i, redirect_pc_i,
        input  arready_i, rvalid_i, rdata_i, rresp_i,
        input  out_ready,
        output arvalid_o, araddr_o, rready_o,
        output out_valid, pc_o, instruction_o, fetch_err_o
    );

    // Memory, back end and IF/ID side
    modport slave (
        output flush_i, redirect_pc_i,
        output arready_i, rvalid_i, rdata_i, rresp_i,
        output out_ready,
        input  arvalid_o, araddr_o, rready_o,
        input  out_valid, pc_o, instruction_o, fetch_err_o
    );

endinterface

// File: rtl/ysyx_24100006_ifu.sv
// rtl/ysyx_24100006_ifu.sv - instruction fetch unit with redirect and in-flight drop
module ysyx_24100006_ifu
    import ysyx_24100006_pkg::*;
#(
    parameter logic [31:0] RESET_PC_P = RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    ysyx_24100006_ifu_if.master bus
);

    ifu_state_t  state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] inst_q;
    logic        err_q;
    logic        drop_q;
    logic [31:0] redir_pc_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        out_valid_q;
    logic [31:0] target;

    // Redirect targets are always word aligned.
    assign target = bus.redirect_pc_i & ~32'h3;

    assign bus.arvalid_o     = arvalid_q;
    assign bus.araddr_o      = fetch_pc_q;
    assign bus.rready_o      = rready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.pc_o          = fetch_pc_q;
    assign bus.instruction_o = inst_q;
    assign bus.fetch_err_o   = err_q;

    // Fetch FSM; handshake outputs are registered so reset holds them low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_AR;
            fetch_pc_q  <= RESET_PC_P;
            inst_q      <= '0;
            err_q       <= 1'b0;
            drop_q      <= 1'b0;
            redir_pc_q  <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_AR: begin
                    if (arvalid_q && bus.arready_i) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_R;
                    end else begin
                        arvalid_q <= 1'b1;
                    end
                    // The address already on the bus stays put; only remember the target.
                    if (bus.flush_i) begin
                        drop_q     <= 1'b1;
                        redir_pc_q <= target;
                    end
                end
                S_R: begin
                    if (rready_q && bus.rvalid_i) begin
                        rready_q <= 1'b0;
                        if (drop_q || bus.flush_i) begin
                            // A same-cycle flush is the newest redirect and wins.
                            fetch_pc_q <= bus.flush_i ? target : redir_pc_q;
                            drop_q     <= 1'b0;
                            arvalid_q  <= 1'b1;
                            state_q    <= S_AR;
                        end else begin
                            inst_q      <= bus.rdata_i;
                            err_q       <= (bus.rresp_i != RESP_OKAY);
                            out_valid_q <= 1'b1;
                            state_q     <= S_OUT;
                        end
                    end else if (bus.flush_i) begin
                        drop_q     <= 1'b1;
                        redir_pc_q <= target;
                    end
                end
                S_OUT: begin
                    // IF/ID flushes alongside us, so the redirect beats the handshake.
                    if (bus.flush_i) begin
                        fetch_pc_q  <= target;
                        out_valid_q <= 1'b0;
                        arvalid_q   <= 1'b1;
                        state_q     <= S_AR;
                    end else if (out_valid_q && bus.out_ready) begin
                        fetch_pc_q  <= fetch_pc_q + 32'd4;
                        out_valid_q <= 1'b0;
                        arvalid_q   <= 1'b1;
                        state_q     <= S_AR;
                    end
                end
                default: begin
                    state_q <= S_AR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24100006_ifu.sv
// tb/tb_ysyx_24100006_ifu.sv - self-checking bench for ysyx_24100006_ifu
module tb_ysyx_24100006_ifu;

    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_total = 0;

    ysyx_24100006_ifu_if bus();

    ysyx_24100006_ifu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ar_wait;
        int          r_wait;
        int          out_wait;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic idle_inputs();
        bus.flush_i       = 1'b0;
        bus.redirect_pc_i = '0;
        bus.arready_i     = 1'b0;
        bus.rvalid_i      = 1'b0;
        bus.rdata_i       = '0;
        bus.rresp_i       = 2'b00;
        bus.out_ready     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // One complete undisturbed fetch with configurable stalls on every handshake.
    task automatic fetch_one(input vec_t v);
        int n = 0;
        while (!bus.arvalid_o && n < 20) begin
            tick();
            n++;
        end
        chk("ar_issue", {31'd0, bus.arvalid_o}, 32'd1);
        chk("araddr", bus.araddr_o, v.pc);
        bus.arready_i = 1'b0;
        repeat (v.ar_wait) tick();
        chk("araddr_hold", bus.araddr_o, v.pc);
        bus.arready_i = 1'b1;
        tick();
        bus.arready_i = 1'b0;
        chk("rready", {31'd0, bus.rready_o}, 32'd1);
        repeat (v.r_wait) tick();
        bus.rvalid_i = 1'b1;
        bus.rdata_i  = v.rdata;
        bus.rresp_i  = v.rresp;
        tick();
        bus.rvalid_i = 1'b0;
        bus.rresp_i  = 2'b00;
        chk("out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("pc_o", bus.pc_o, v.pc);
        chk("instruction_o", bus.instruction_o, v.inst);
        chk("fetch_err_o", {31'd0, bus.fetch_err_o}, {31'd0, v.err});
        bus.out_ready = 1'b0;
        repeat (v.out_wait) tick();
        if (v.out_wait > 0) begin
            chk("stall_pc", bus.pc_o, v.pc);
            chk("stall_inst", bus.instruction_o, v.inst);
            chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("stall_no_ar", {31'd0, bus.arvalid_o}, 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("post_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("next_ar", {31'd0, bus.arvalid_o}, 32'd1);
        chk("next_araddr", bus.araddr_o, v.pc + 32'd4);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic [1:0] mem_resp(input logic [31:0] a);
        return (a[5:2] == 4'hB) ? 2'b10 : 2'b00;
    endfunction

    // Random traffic against a transaction-level model: after any flush the next
    // delivered instruction is the flush target, otherwise the previous pc + 4.
    task automatic random_phase(input int cycles);
        logic [31:0] exp_pc = 32'h8000_0000;
        logic        pend = 1'b0;
        logic [31:0] pend_addr = '0;
        int          pend_delay = 0;
        logic        prev_ar = 1'b0;
        logic [31:0] prev_addr = '0;
        int          since = 0;
        int          delivered = 0;
        logic        ar_v, rv_v, or_v, fl_v;
        logic [31:0] tgt;
        for (int c = 0; c < cycles; c++) begin
            if (prev_ar) begin
                chk("rnd_ar_hold_valid", {31'd0, bus.arvalid_o}, 32'd1);
                chk("rnd_ar_hold_addr", bus.araddr_o, prev_addr);
            end
            ar_v = ($urandom_range(0, 2) != 0);
            rv_v = pend && (pend_delay == 0);
            or_v = ($urandom_range(0, 1) != 0);
            fl_v = ($urandom_range(0, 14) == 0);
            tgt  = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
            bus.arready_i     = ar_v;
            bus.rvalid_i      = rv_v;
            bus.rdata_i       = rv_v ? mem_word(pend_addr) : 32'h0;
            bus.rresp_i       = rv_v ? mem_resp(pend_addr) : 2'b00;
            bus.out_ready     = or_v;
            bus.flush_i       = fl_v;
            bus.redirect_pc_i = tgt;
            if (bus.out_valid && or_v && !fl_v) begin
                chk("rnd_pc", bus.pc_o, exp_pc);
                chk("rnd_inst", bus.instruction_o, mem_word(exp_pc));
                chk("rnd_err", {31'd0, bus.fetch_err_o}, {31'd0, (mem_resp(exp_pc) != 2'b00)});
                exp_pc = exp_pc + 32'd4;
                delivered++;
                since = 0;
            end else begin
                since++;
            end
            if (fl_v) exp_pc = {tgt[31:2], 2'b00};
            if (rv_v && bus.rready_o) pend = 1'b0;
            else if (pend && pend_delay > 0) pend_delay--;
            if (bus.arvalid_o && ar_v) begin
                pend       = 1'b1;
                pend_addr  = bus.araddr_o;
                pend_delay = $urandom_range(0, 3);
            end
            prev_ar   = bus.arvalid_o && !ar_v;
            prev_addr = bus.araddr_o;
            if (since > 200) begin
                chk("rnd_progress", since, 0);
                break;
            end
            tick();
        end
        idle_inputs();
        n_total++;
        if (delivered < 100)
            $display("FAIL rnd_delivered: got %0d expected at least 100", delivered);
        else
            n_pass++;
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{0, 0, 0, 32'h0000_0413, 2'b00, 32'h8000_0000, 32'h0000_0413, 1'b0};
        vecs[1] = '{0, 0, 5, 32'h0010_0093, 2'b00, 32'h8000_0004, 32'h0010_0093, 1'b0};
        vecs[2] = '{2, 1, 1, 32'hDEAD_BEEF, 2'b10, 32'h8000_0008, 32'hDEAD_BEEF, 1'b1};
        vecs[3] = '{1, 3, 0, 32'h1234_5678, 2'b01, 32'h8000_000C, 32'h1234_5678, 1'b1};
        vecs[4] = '{0, 0, 0, 32'h0000_006F, 2'b00, 32'h8000_0010, 32'h0000_006F, 1'b0};

        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        chk("rst_arvalid", {31'd0, bus.arvalid_o}, 32'd0);
        chk("rst_rready", {31'd0, bus.rready_o}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_pc", bus.pc_o, 32'h8000_0000);
        chk("rst_inst", bus.instruction_o, 32'h0);
        chk("rst_err", {31'd0, bus.fetch_err_o}, 32'd0);
        reset = 1'b1;
        tick();
        chk("first_arvalid", {31'd0, bus.arvalid_o}, 32'd1);
        chk("first_araddr", bus.araddr_o, 32'h8000_0000);

        for (int i = 0; i < 5; i++) fetch_one(vecs[i]);

        // Flush while AR is stalled: address holds, response dropped, redirect fetched.
        do_reset();
        tick();
        bus.flush_i = 1'b1;
        bus.redirect_pc_i = 32'h8000_1000;
        tick();
        bus.flush_i = 1'b0;
        chk("a_hold1", bus.araddr_o, 32'h8000_0000);
        tick();
        tick();
        chk("a_hold2", bus.araddr_o, 32'h8000_0000);
        bus.arready_i = 1'b1;
        tick();
        bus.arready_i = 1'b0;
        bus.rvalid_i = 1'b1;
        bus.rdata_i = 32'hBAD0_0001;
        tick();
        bus.rvalid_i = 1'b0;
        chk("a_dropped", {31'd0, bus.out_valid}, 32'd0);
        chk("a_redir", bus.araddr_o, 32'h8000_1000);
        v = '{0, 0, 0, 32'h1111_1111, 2'b00, 32'h8000_1000, 32'h1111_1111, 1'b0};
        fetch_one(v);

        // Flush coincident with the read response, unaligned target.
        bus.arready_i = 1'b1;
        tick();
        bus.arready_i = 1'b0;
        bus.rvalid_i = 1'b1;
        bus.rdata_i = 32'hBAD0_0002;
        bus.flush_i = 1'b1;
        bus.redirect_pc_i = 32'h8000_4003;
        tick();
        bus.rvalid_i = 1'b0;
        bus.flush_i = 1'b0;
        chk("b_dropped", {31'd0, bus.out_valid}, 32'd0);
        chk("b_redir", bus.araddr_o, 32'h8000_4000);
        tick();
        tick();
        chk("b_still_dropped", {31'd0, bus.out_valid}, 32'd0);
        v = '{0, 0, 0, 32'h2222_2222, 2'b00, 32'h8000_4000, 32'h2222_2222, 1'b0};
        fetch_one(v);

        // Two flushes during one read wait: one drop, last target wins.
        bus.arready_i = 1'b1;
        tick();
        bus.arready_i = 1'b0;
        bus.flush_i = 1'b1;
        bus.redirect_pc_i = 32'h8000_2000;
        tick();
        bus.flush_i = 1'b0;
        tick();
        bus.flush_i = 1'b1;
        bus.redirect_pc_i = 32'h8000_3000;
        tick();
        bus.flush_i = 1'b0;
        bus.rvalid_i = 1'b1;
        bus.rdata_i = 32'hBAD0_0003;
        tick();
        bus.rvalid_i = 1'b0;
        chk("c_dropped", {31'd0, bus.out_valid}, 32'd0);
        chk("c_redir", bus.araddr_o, 32'h8000_3000);
        v = '{0, 0, 0, 32'h3333_3333, 2'b00, 32'h8000_3000, 32'h3333_3333, 1'b0};
        fetch_one(v);

        // Flush in the output stage overrides a same-cycle handshake.
        bus.arready_i = 1'b1;
        tick();
        bus.arready_i = 1'b0;
        bus.rvalid_i = 1'b1;
        bus.rdata_i = 32'h4444_4444;
        tick();
        bus.rvalid_i = 1'b0;
        chk("d_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("d_pc", bus.pc_o, 32'h8000_3004);
        bus.out_ready = 1'b1;
        bus.flush_i = 1'b1;
        bus.redirect_pc_i = 32'h8000_5000;
        tick();
        bus.out_ready = 1'b0;
        bus.flush_i = 1'b0;
        chk("d_valid_drop", {31'd0, bus.out_valid}, 32'd0);
        chk("d_redir", bus.araddr_o, 32'h8000_5000);
        v = '{0, 0, 0, 32'h5555_5555, 2'b00, 32'h8000_5000, 32'h5555_5555, 1'b0};
        fetch_one(v);

        do_reset();
        random_phase(3000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
